// File: rtl/regfile_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue: default widths,
// the hardwired-zero register index and the queue entry record.
package regfile_wb_queue_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_fwd_match.sv
// Scans the pending queue entries oldest-to-youngest for a register index;
// the last match found is the youngest, so it wins.
module fwd_match
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_reg,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [$clog2(DEPTH)-1:0]     i_head,
    input  logic [$clog2(DEPTH):0]       i_count,
    input  logic [ADDR_W-1:0]            i_query,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PTR_W'(i);
            if ((CNT_W'(i) < i_count) && i_valid[w_idx] &&
                (i_reg[w_idx] == i_query) && (i_query != ADDR_W'(REG_ZERO))) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the register file write port, with
// combinational forwarding of pending values to the two read ports.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_stall,
    output logic                     wb_writeEnable,
    output logic [ADDR_W-1:0]        wb_writeReg,
    output logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        query_regA,
    input  logic [ADDR_W-1:0]        query_regB,
    output logic                     fwd_hitA,
    output logic                     fwd_hitB,
    output logic [DATA_W-1:0]        fwd_dataA,
    output logic [DATA_W-1:0]        fwd_dataB,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] r_reg;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    logic w_accept;
    logic w_push;
    logic w_pop;

    // in_ready depends only on registered occupancy, never on wb_stall.
    assign in_ready = (r_count != CNT_W'(DEPTH));
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & (in_reg != ADDR_W'(REG_ZERO));
    assign w_pop    = (r_count != '0) & ~wb_stall;

    assign wb_writeEnable = w_pop;
    assign wb_writeReg    = r_reg[r_head];
    assign wb_data        = r_data[r_head];
    assign count          = r_count;
    assign empty          = (r_count == '0);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_reg[r_tail]  <= in_reg;
            r_data[r_tail] <= in_data;
        end
    end

    fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .i_valid (r_valid),
        .i_reg   (r_reg),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_query (query_regA),
        .o_hit   (fwd_hitA),
        .o_data  (fwd_dataA)
    );

    fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .i_valid (r_valid),
        .i_reg   (r_reg),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_query (query_regB),
        .o_hit   (fwd_hitB),
        .o_data  (fwd_dataB)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a negedge
// monitor pops and compares each write the queue presents.
module tb_regfile_wb_queue;
    import regfile_wb_queue_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        wb_writeEnable;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_data;
    logic [4:0]  query_regA;
    logic [4:0]  query_regB;
    logic        fwd_hitA;
    logic        fwd_hitB;
    logic [31:0] fwd_dataA;
    logic [31:0] fwd_dataB;
    logic [2:0]  count;
    logic        empty;

    int checks     = 0;
    int failures   = 0;
    int writes_seen = 0;
    wb_entry_t exp_q[$];

    always #5 clock = ~clock;

    regfile_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg         (in_reg),
        .in_data        (in_data),
        .wb_stall       (wb_stall),
        .wb_writeEnable (wb_writeEnable),
        .wb_writeReg    (wb_writeReg),
        .wb_data        (wb_data),
        .query_regA     (query_regA),
        .query_regB     (query_regB),
        .fwd_hitA       (fwd_hitA),
        .fwd_hitB       (fwd_hitB),
        .fwd_dataA      (fwd_dataA),
        .fwd_dataB      (fwd_dataB),
        .count          (count),
        .empty          (empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic enq(input logic [4:0] r, input logic [31:0] d, input logic exp_acc);
        wb_entry_t e;
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        @(negedge clock);
        chk("enq_in_ready", 32'(in_ready), 32'(exp_acc));
        @(posedge clock);
        if (exp_acc && r != 5'd0) begin
            e.valid = 1'b1;
            e.rd    = r;
            e.data  = d;
            exp_q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!ctrl_reset && wb_writeEnable) begin
            wb_entry_t e;
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: reg %0d data 0x%08h, none expected at %0t",
                         wb_writeReg, wb_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wb_writeReg", 32'(wb_writeReg), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        int w0;
        ctrl_reset = 1'b1;
        in_valid   = 1'b0;
        in_reg     = '0;
        in_data    = '0;
        wb_stall   = 1'b0;
        query_regA = '0;
        query_regB = '0;
        repeat (2) @(posedge clock);
        #1 ctrl_reset = 1'b0;

        // Reset / idle state
        @(negedge clock);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wbE", 32'(wb_writeEnable), 32'd0);
        chk("rst_hitA", 32'(fwd_hitA), 32'd0);
        chk("rst_dataA", fwd_dataA, 32'd0);
        cycle();

        // Single write, one-cycle latency; same-cycle request not forwarded
        query_regA = 5'd5;
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEADBEEF;
        @(negedge clock);
        chk("samecyc_hitA", 32'(fwd_hitA), 32'd0);
        @(posedge clock);
        exp_q.push_back('{valid: 1'b1, rd: 5'd5, data: 32'hDEADBEEF});
        #1 in_valid = 1'b0;
        @(negedge clock);
        chk("lat_wbE", 32'(wb_writeEnable), 32'd1);
        chk("inflight_hitA", 32'(fwd_hitA), 32'd1);
        chk("inflight_dataA", fwd_dataA, 32'hDEADBEEF);
        cycle();
        @(negedge clock);
        chk("after_drain_empty", 32'(empty), 32'd1);
        chk("after_drain_hitA", 32'(fwd_hitA), 32'd0);
        cycle();

        // Two writes to r3 under stall: youngest wins in forwarding
        wb_stall = 1'b1;
        query_regA = 5'd3;
        query_regB = 5'd4;
        enq(5'd3, 32'h11, 1'b1);
        enq(5'd3, 32'h22, 1'b1);
        @(negedge clock);
        chk("stall_count", 32'(count), 32'd2);
        chk("stall_wbE", 32'(wb_writeEnable), 32'd0);
        chk("young_hitA", 32'(fwd_hitA), 32'd1);
        chk("young_dataA", fwd_dataA, 32'h22);
        chk("miss_hitB", 32'(fwd_hitB), 32'd0);
        chk("miss_dataB", fwd_dataB, 32'd0);
        cycle();
        wb_stall = 1'b0;
        @(negedge clock);
        chk("drain_hitA", 32'(fwd_hitA), 32'd1);
        chk("drain_dataA", fwd_dataA, 32'h22);
        repeat (2) cycle();
        @(negedge clock);
        chk("r3_empty", 32'(empty), 32'd1);
        cycle();

        // Fill to DEPTH, reject a fifth, then drain back-to-back
        wb_stall = 1'b1;
        enq(5'd1, 32'hA001, 1'b1);
        enq(5'd2, 32'hA002, 1'b1);
        enq(5'd3, 32'hA003, 1'b1);
        enq(5'd4, 32'hA004, 1'b1);
        @(negedge clock);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        enq(5'd6, 32'hA006, 1'b0);
        @(negedge clock);
        chk("full_count_hold", 32'(count), 32'd4);
        cycle();
        wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("b2b_wbE", 32'(wb_writeEnable), 32'd1);
            cycle();
        end
        @(negedge clock);
        chk("full_drained_empty", 32'(empty), 32'd1);
        cycle();

        // Register 0 is accepted but never stored or forwarded
        query_regB = 5'd0;
        enq(5'd0, 32'h55, 1'b1);
        @(negedge clock);
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_wbE", 32'(wb_writeEnable), 32'd0);
        chk("r0_hitB", 32'(fwd_hitB), 32'd0);
        cycle();

        // Asynchronous reset with two entries pending discards them
        wb_stall = 1'b1;
        enq(5'd8, 32'hB008, 1'b1);
        enq(5'd9, 32'hB009, 1'b1);
        wb_stall = 1'b0;
        #2 ctrl_reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_wbE", 32'(wb_writeEnable), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        exp_q.delete();
        w0 = writes_seen;
        cycle();
        ctrl_reset = 1'b0;
        repeat (5) cycle();
        chk("post_rst_writes", 32'(writes_seen - w0), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side initiator for the 32x32 register file.
- Buffers writeback requests from the pipeline in a small in-order queue and drains one entry per cycle onto the register file's single write port (writeEnable / writeReg / data).
- Provides combinational forwarding of still-pending values, so readers of the register file never see stale data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- DATA_W, 32, data width.
- ADDR_W, 5, register index width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_reg  in  ADDR_W  destination register index.
- in_data  in  DATA_W  value to write.
- wb_stall  in  1  holds draining while high; write port is in use elsewhere.
- wb_writeEnable  out  1  drives the register file ctrl_writeEnable.
- wb_writeReg  out  ADDR_W  drives the register file ctrl_writeReg.
- wb_data  out  DATA_W  drives the register file data_writeReg.
- query_regA  in  ADDR_W  index being read on register file port A.
- query_regB  in  ADDR_W  index being read on register file port B.
- fwd_hitA  out  1  a pending entry matches query_regA.
- fwd_hitB  out  1  a pending entry matches query_regB.
- fwd_dataA  out  DATA_W  youngest matching pending value for A; 0 when no hit.
- fwd_dataB  out  DATA_W  youngest matching pending value for B; 0 when no hit.
- count  out  log2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, ctrl_reset=1): head=tail=0, count=0, all entry valid bits cleared. Outputs go to empty=1, in_ready=1, wb_writeEnable=0, fwd_hit*=0, fwd_data*=0. Entry data is not cleared.
- Reset mid-operation discards all pending entries; nothing is written afterwards.
- Enqueue: occurs on an edge where in_valid & in_ready. The entry is stored at tail, and tail advances modulo DEPTH.
- Enqueue to register 0: the request is accepted (handshake completes) but not stored; count is unchanged. Register 0 is hardwired zero.
- Drain: in any cycle with !empty & !wb_stall:
  - wb_writeEnable=1 and wb_writeReg/wb_data = head entry, driven combinationally from the queue registers.
  - The entry pops on that clock edge and head advances modulo DEPTH.
  - Otherwise wb_writeEnable=0 and wb_writeReg/wb_data hold the head entry contents (don't-care).
- Latency: a request accepted at edge N is presented on wb_* during cycle N+1 (if the queue was empty and there is no stall). It is written into the register file at edge N+1.
- Simultaneous enqueue and drain: both occur in the same cycle and count is unchanged.
- Full: when count==DEPTH, in_ready=0 even if a drain happens that same cycle. in_ready has no combinational path from wb_stall.
- Empty: no drain occurs and wb_writeEnable=0 regardless of wb_stall.
- Pointer wrap-around: occupancy is determined by count, never by pointer equality alone.
- Forwarding, matching: purely combinational over valid entries only. Query index 0 never hits.
- Forwarding, priority: among multiple matches, the youngest entry (closest to tail) wins.
- Forwarding, head in flight: the head entry being drained this cycle still counts as a hit, because the register file only updates at the edge.
- Forwarding, same-cycle requests: a request on in_* in the same cycle is NOT forwarded.
- No state machine beyond the queue. The only state is head, tail, count and the per-entry {valid, reg, data} fields.

Decomposition:
- Shared package holds: DATA_W/ADDR_W defaults, REG_ZERO = 5'd0, and the entry record {valid, reg[ADDR_W], data[DATA_W]}.
- One sub-module, fwd_match: given the entry array, head, count and a query index, it returns {hit, data} with youngest-wins priority. It is instantiated twice (ports A and B).

Test Plan:
- Reset then idle, no stall -> empty=1, count=0, in_ready=1, wb_writeEnable=0, fwd_hitA=0.
- Enqueue (r5, 0xDEADBEEF) with no stall -> next cycle wb_writeEnable=1, wb_writeReg=5, wb_data=0xDEADBEEF. Following cycle empty=1.
- wb_stall=1, enqueue r3=0x11 then r3=0x22 -> count=2. query_regA=3 gives fwd_hitA=1, fwd_dataA=0x22. After releasing the stall, the writes appear in order 0x11 then 0x22.
- wb_stall=1, enqueue 4 entries (r1..r4) -> count=4, in_ready=0. A fifth in_valid is not accepted. Releasing the stall drains r1..r4 on 4 consecutive cycles.
- Enqueue to r0 (0x55), query_regB=0 -> count stays 0, no wb_writeEnable pulse, fwd_hitB=0.
- With 2 entries pending, assert ctrl_reset asynchronously between edges -> count=0 and wb_writeEnable=0 immediately. No writes occur after reset deasserts.
